// File: rtl/irq_controller_pkg.sv
// Shared constants, state encoding and the fixed-priority helper for the interrupt controller.
package irq_controller_pkg;

  localparam int unsigned IRQ_NUM  = 8;
  localparam int unsigned IRQ_NO_W = 3;

  localparam logic [1:0] IRQ_IDLE = 2'd0;
  localparam logic [1:0] IRQ_REQ  = 2'd1;
  localparam logic [1:0] IRQ_SERV = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IRQ_IDLE,
    StReq  = IRQ_REQ,
    StServ = IRQ_SERV
  } irq_state_e;

  // Lowest set index wins; returns 0 for an empty vector.
  function automatic logic [IRQ_NO_W-1:0] prio_lowest(input logic [IRQ_NUM-1:0] vec);
    prio_lowest = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (vec[i]) begin
        prio_lowest = IRQ_NO_W'(i);
      end
    end
  endfunction

endpackage

// File: rtl/irq_controller_sync.sv
// One interrupt line: SYNC_STAGES-deep synchroniser followed by a prev flop for edge detection.
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  output logic sync,
  output logic rise
);

  if (SYNC_STAGES < 2) begin : g_bad_depth
    $error("irq_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] stages_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stages_q <= '0;
      prev_q   <= 1'b0;
    end else begin
      stages_q <= {stages_q[SYNC_STAGES-2:0], irq_in};
      prev_q   <= stages_q[SYNC_STAGES-1];
    end
  end

  assign sync = stages_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Eight-source interrupt controller: synchronise, latch/mask, fixed-priority select, and hold the
// request to the core until ack, then track in-service until eoi.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [IRQ_NUM-1:0] EDGE_MASK   = 8'hFF,
  parameter logic [IRQ_NUM-1:0] MASK_RESET  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic       mask_wen,
  input  logic [7:0] mask_wdata,
  input  logic       ack,
  input  logic       eoi,
  output logic       interrupter,
  output logic [2:0] interrupter_no,
  output logic       in_service,
  output logic [7:0] pending,
  output logic [7:0] mask
);

  logic [IRQ_NUM-1:0] sync_vec;
  logic [IRQ_NUM-1:0] rise_vec;

  for (genvar g = 0; g < IRQ_NUM; g++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_irq_sync (
      .clk   (clk),
      .rst   (rst),
      .irq_in(irq_in[g]),
      .sync  (sync_vec[g]),
      .rise  (rise_vec[g])
    );
  end

  irq_state_e          state_q;
  logic                interrupter_q;
  logic                in_service_q;
  logic [IRQ_NO_W-1:0] irq_no_q;

  logic [IRQ_NUM-1:0]  pending_q;
  logic [IRQ_NUM-1:0]  pending_d;
  logic [IRQ_NUM-1:0]  mask_q;
  logic [IRQ_NUM-1:0]  eligible;
  logic [IRQ_NUM-1:0]  ack_clr;
  logic                ack_taken;

  assign ack_taken = (state_q == StReq) && ack;
  assign eligible  = pending_q & mask_q;

  // A fresh edge in the ack cycle beats the clear, so the new request is not lost.
  always_comb begin
    pending_d = pending_q;
    ack_clr   = ack_taken ? (IRQ_NUM'(1) << irq_no_q) : '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      if (EDGE_MASK[i]) begin
        pending_d[i] = rise_vec[i] | (pending_q[i] & ~ack_clr[i]);
      end else begin
        pending_d[i] = sync_vec[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q <= '0;
      mask_q    <= MASK_RESET;
    end else begin
      pending_q <= pending_d;
      if (mask_wen) begin
        mask_q <= mask_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      interrupter_q <= 1'b0;
      in_service_q  <= 1'b0;
      irq_no_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (eligible != '0) begin
            state_q       <= StReq;
            interrupter_q <= 1'b1;
            irq_no_q      <= prio_lowest(eligible);
          end
        end
        StReq: begin
          if (ack) begin
            state_q       <= StServ;
            interrupter_q <= 1'b0;
            in_service_q  <= 1'b1;
          end else if (!eligible[irq_no_q]) begin
            // Withdrawn; arbitration restarts from idle on the following cycle.
            state_q       <= StIdle;
            interrupter_q <= 1'b0;
          end
        end
        StServ: begin
          if (eoi) begin
            state_q      <= StIdle;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= StIdle;
          interrupter_q <= 1'b0;
          in_service_q  <= 1'b0;
        end
      endcase
    end
  end

  assign interrupter    = interrupter_q;
  assign interrupter_no = irq_no_q;
  assign in_service     = in_service_q;
  assign pending        = pending_q;
  assign mask           = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irq_in = 8'h00;
  logic       mask_wen = 1'b0;
  logic [7:0] mask_wdata = 8'h00;
  logic       ack = 1'b0;
  logic       eoi = 1'b0;

  logic       int0, isv0, int1, isv1;
  logic [2:0] no0, no1;
  logic [7:0] pend0, mask0, pend1, mask1;

  always #5 clk = ~clk;

  irq_controller u_dut0 (
    .clk           (clk),
    .rst           (rst),
    .irq_in        (irq_in),
    .mask_wen      (mask_wen),
    .mask_wdata    (mask_wdata),
    .ack           (ack),
    .eoi           (eoi),
    .interrupter   (int0),
    .interrupter_no(no0),
    .in_service    (isv0),
    .pending       (pend0),
    .mask          (mask0)
  );

  irq_controller #(
    .SYNC_STAGES(3),
    .EDGE_MASK  (8'h0F),
    .MASK_RESET (8'hA5)
  ) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .irq_in        (irq_in),
    .mask_wen      (mask_wen),
    .mask_wdata    (mask_wdata),
    .ack           (ack),
    .eoi           (eoi),
    .interrupter   (int1),
    .interrupter_no(no1),
    .in_service    (isv1),
    .pending       (pend1),
    .mask          (mask1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model, one slot per instance. hist[d][j] = irq_in sampled j+1 edges ago.
  int         ss[2];
  logic [7:0] em[2];
  logic [7:0] mr[2];
  logic [7:0] hist[2][8];
  int         m_st[2];  // 0 idle, 1 requesting, 2 servicing
  logic [2:0] m_no[2];
  logic [7:0] m_pend[2];
  logic [7:0] m_mask[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic model_step(input int d);
    logic [7:0] sync, prev, rise, elig, clr, np;
    if (!rst) begin
      for (int j = 0; j < 8; j++) hist[d][j] = 8'h00;
      m_pend[d] = 8'h00;
      m_mask[d] = mr[d];
      m_st[d]   = 0;
      m_no[d]   = 3'd0;
      return;
    end
    sync = hist[d][ss[d]-1];
    prev = hist[d][ss[d]];
    rise = sync & ~prev;
    elig = m_pend[d] & m_mask[d];
    clr  = (m_st[d] == 1 && ack) ? (8'd1 << m_no[d]) : 8'd0;
    for (int i = 0; i < 8; i++) begin
      np[i] = em[d][i] ? (rise[i] | (m_pend[d][i] & ~clr[i])) : sync[i];
    end
    case (m_st[d])
      0: if (elig != 8'h00) begin
        m_st[d] = 1;
        m_no[d] = lowest(elig);
      end
      1: if (ack) m_st[d] = 2;
         else if (!elig[m_no[d]]) m_st[d] = 0;
      default: if (eoi) m_st[d] = 0;
    endcase
    m_pend[d] = np;
    if (mask_wen) m_mask[d] = mask_wdata;
    for (int j = 7; j > 0; j--) hist[d][j] = hist[d][j-1];
    hist[d][0] = irq_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("dut0.interrupter", int0, m_st[0] == 1);
    check("dut0.in_service", isv0, m_st[0] == 2);
    check("dut0.interrupter_no", no0, m_no[0]);
    check("dut0.pending", pend0, m_pend[0]);
    check("dut0.mask", mask0, m_mask[0]);
    check("dut1.interrupter", int1, m_st[1] == 1);
    check("dut1.in_service", isv1, m_st[1] == 2);
    check("dut1.interrupter_no", no1, m_no[1]);
    check("dut1.pending", pend1, m_pend[1]);
    check("dut1.mask", mask1, m_mask[1]);
  endtask

  // Two-cycle pulse on the given lines, then wait until the default instance presents it.
  task automatic pulse_and_wait(input logic [7:0] lines);
    irq_in = lines;
    tick();
    tick();
    irq_in = 8'h00;
    tick();
    tick();
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  initial begin
    ss = '{2, 3};
    em = '{8'hFF, 8'h0F};
    mr = '{8'h00, 8'hA5};

    // Reset with all lines high.
    rst = 1'b0;
    irq_in = 8'hFF;
    tick();
    tick();
    check("reset.interrupter", int0, 1'b0);
    check("reset.pending", pend0, 8'h00);
    check("reset.mask", mask0, 8'h00);
    check("reset.in_service", isv0, 1'b0);
    check("reset.mask_dut1", mask1, 8'hA5);
    rst = 1'b1;
    tick();
    tick();
    check("release.pending_early", pend0, 8'h00);
    tick();
    check("release.pending", pend0, 8'hFF);
    check("release.no_request", int0, 1'b0);

    // Clean restart and enable all sources.
    rst = 1'b0;
    irq_in = 8'h00;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    mask_wen = 1'b1;
    mask_wdata = 8'hFF;
    tick();
    mask_wen = 1'b0;
    check("mask.write", mask0, 8'hFF);

    // Single source latency and ack/eoi handshake.
    irq_in = 8'h20;
    tick();
    tick();
    irq_in = 8'h00;
    tick();
    check("lat.pending5", pend0, 8'h20);
    check("lat.not_yet", int0, 1'b0);
    tick();
    check("lat.interrupter", int0, 1'b1);
    check("lat.no5", no0, 3'd5);
    do_ack();
    check("ack.pending_clr", pend0, 8'h00);
    check("ack.in_service", isv0, 1'b1);
    check("ack.int_low", int0, 1'b0);
    do_eoi();
    check("eoi.idle", isv0, 1'b0);

    // Simultaneous sources: lower index first, then the other after one idle cycle.
    pulse_and_wait(8'h44);
    check("prio.first", no0, 3'd2);
    do_ack();
    do_eoi();
    check("prio.idle_gap", int0, 1'b0);
    tick();
    check("prio.second_int", int0, 1'b1);
    check("prio.second_no", no0, 3'd6);
    do_ack();
    do_eoi();

    // Masking a presented source withdraws it; unmasking re-presents it.
    pulse_and_wait(8'h08);
    check("wd.no3", no0, 3'd3);
    mask_wen = 1'b1;
    mask_wdata = 8'hF7;
    tick();
    mask_wen = 1'b0;
    tick();
    check("wd.dropped", int0, 1'b0);
    check("wd.pending_kept", pend0, 8'h08);
    mask_wen = 1'b1;
    mask_wdata = 8'hFF;
    tick();
    mask_wen = 1'b0;
    tick();
    check("wd.represent", int0, 1'b1);
    check("wd.represent_no", no0, 3'd3);
    do_ack();
    do_eoi();

    // New edge coinciding with the ack of the same source keeps it pending.
    pulse_and_wait(8'h10);
    check("reedge.no4", no0, 3'd4);
    irq_in = 8'h10;
    tick();
    tick();
    irq_in = 8'h00;
    do_ack();
    check("reedge.serv", isv0, 1'b1);
    check("reedge.pending", pend0, 8'h10);
    do_eoi();
    check("reedge.gap", int0, 1'b0);
    tick();
    check("reedge.again", int0, 1'b1);
    check("reedge.again_no", no0, 3'd4);
    do_ack();
    do_eoi();

    // Reset while servicing with another source pending.
    pulse_and_wait(8'h82);
    check("rstsvc.no1", no0, 3'd1);
    do_ack();
    check("rstsvc.pending", pend0, 8'h80);
    rst = 1'b0;
    tick();
    check("rstsvc.int", int0, 1'b0);
    check("rstsvc.isv", isv0, 1'b0);
    check("rstsvc.no", no0, 3'd0);
    check("rstsvc.pending_clr", pend0, 8'h00);
    check("rstsvc.mask", mask0, 8'h00);
    rst = 1'b1;

    // Random traffic, all outputs compared to the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) irq_in = 8'($urandom);
      ack        = ($urandom_range(0, 2) == 0);
      eoi        = ($urandom_range(0, 3) == 0);
      mask_wen   = ($urandom_range(0, 7) == 0);
      mask_wdata = 8'($urandom);
      rst        = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
